// File: rtl/sprite_line_scanner.sv
// rtl/sprite_line_scanner.sv - per-line sprite table scan into 4 slots, plus per-pixel hit descriptors.
module sprite_line_scanner #(
   parameter int NUM_ENTRIES = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_we,
   input  logic [4:0]  cfg_addr,
   input  logic [34:0] cfg_wdata,
   input  logic        frame_start,
   input  logic        line_start,
   input  logic [9:0]  line_y,
   input  logic        new_pixel,
   input  logic [9:0]  pixel_x,
   output logic [22:0] h0_out,
   output logic [22:0] h1_out,
   output logic [22:0] h2_out,
   output logic [22:0] h3_out,
   output logic        h_valid,
   output logic        scan_busy,
   output logic        line_overflow
);

   localparam int IW = $clog2(NUM_ENTRIES);

   typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] level;
      logic [8:0] id;
      logic [9:0] x;
      logic [3:0] dy;
   } slot_t;

   logic [34:0]   table_q [NUM_ENTRIES];
   state_t        state_q;
   logic [IW-1:0] index_q;
   logic [9:0]    line_q;
   slot_t         pend_q [4];
   slot_t         act_q [4];
   logic [2:0]    pend_cnt_q;
   logic          pend_ovf_q;
   logic          ovf_q;
   logic [22:0]   h_q [4];
   logic          h_valid_q;

   logic [34:0] ent;
   logic [9:0]  ent_dy;
   logic        ent_match;

   // Entry under scan; a same-cycle config write is only visible next cycle.
   assign ent       = table_q[index_q];
   assign ent_dy    = line_q - ent[9:0];
   assign ent_match = ent[34] && (ent[33:25] != 9'd0) && (ent_dy[9:4] == 6'd0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ENTRIES; i++) table_q[i] <= '0;
      end else if (cfg_we) begin
         table_q[cfg_addr] <= cfg_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || frame_start) begin
         state_q    <= IDLE;
         index_q    <= '0;
         pend_cnt_q <= '0;
         pend_ovf_q <= 1'b0;
         ovf_q      <= 1'b0;
         for (int k = 0; k < 4; k++) begin
            pend_q[k] <= '0;
            act_q[k]  <= '0;
         end
         if (!rst_n) line_q <= '0;
      end else if (line_start) begin
         // Also restarts a scan in progress; active slots stay as they are.
         state_q    <= SCAN;
         line_q     <= line_y;
         index_q    <= '0;
         pend_cnt_q <= '0;
         pend_ovf_q <= 1'b0;
         for (int k = 0; k < 4; k++) pend_q[k] <= '0;
      end else begin
         case (state_q)
            SCAN: begin
               if (ent_match) begin
                  if (pend_cnt_q[2]) begin
                     pend_ovf_q <= 1'b1;
                  end else begin
                     pend_q[pend_cnt_q[1:0]] <= {1'b1, ent[24:20], ent[33:25], ent[19:10], ent_dy[3:0]};
                     pend_cnt_q <= pend_cnt_q + 3'd1;
                  end
               end
               index_q <= index_q + 1'b1;
               if (index_q == IW'(NUM_ENTRIES - 1)) state_q <= COMMIT;
            end
            COMMIT: begin
               for (int k = 0; k < 4; k++) act_q[k] <= pend_q[k];
               ovf_q   <= pend_ovf_q;
               state_q <= IDLE;
            end
            default: ;
         endcase
      end
   end

   logic [9:0] dx [4];
   logic       hit [4];
   logic       border [4];

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         dx[k]     = pixel_x - act_q[k].x;
         hit[k]    = act_q[k].valid && (dx[k][9:4] == 6'd0);
         border[k] = (dx[k][3:0] == 4'd0) || (dx[k][3:0] == 4'd15) ||
                     (act_q[k].dy == 4'd0) || (act_q[k].dy == 4'd15);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h_valid_q <= 1'b0;
         for (int k = 0; k < 4; k++) h_q[k] <= '0;
      end else begin
         h_valid_q <= new_pixel;
         if (new_pixel) begin
            for (int k = 0; k < 4; k++)
               h_q[k] <= hit[k] ? {act_q[k].level, act_q[k].id, dx[k][3:0], act_q[k].dy, border[k]} : 23'd0;
         end
      end
   end

   assign h0_out        = h_q[0];
   assign h1_out        = h_q[1];
   assign h2_out        = h_q[2];
   assign h3_out        = h_q[3];
   assign h_valid       = h_valid_q;
   assign scan_busy     = (state_q != IDLE);
   assign line_overflow = ovf_q;

endmodule

// File: tb/tb_sprite_line_scanner.sv
// tb/tb_sprite_line_scanner.sv - directed bench for sprite_line_scanner.
module tb_sprite_line_scanner;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_we = 1'b0;
   logic [4:0]  cfg_addr = '0;
   logic [34:0] cfg_wdata = '0;
   logic        frame_start = 1'b0;
   logic        line_start = 1'b0;
   logic [9:0]  line_y = '0;
   logic        new_pixel = 1'b0;
   logic [9:0]  pixel_x = '0;
   logic [22:0] h0_out, h1_out, h2_out, h3_out;
   logic        h_valid, scan_busy, line_overflow;

   int n_checks = 0;
   int n_fail = 0;
   bit busy_ok;

   sprite_line_scanner #(.NUM_ENTRIES(32)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .frame_start(frame_start), .line_start(line_start), .line_y(line_y),
      .new_pixel(new_pixel), .pixel_x(pixel_x),
      .h0_out(h0_out), .h1_out(h1_out), .h2_out(h2_out), .h3_out(h3_out),
      .h_valid(h_valid), .scan_busy(scan_busy), .line_overflow(line_overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [22:0] hd(input int lvl, input int id, input int dxv, input int dyv, input int b);
      logic [4:0] l5 = lvl[4:0];
      logic [8:0] i9 = id[8:0];
      logic [3:0] x4 = dxv[3:0];
      logic [3:0] y4 = dyv[3:0];
      return {l5, i9, x4, y4, b[0]};
   endfunction

   task automatic chk_h(input string tag, input logic [22:0] e0, input logic [22:0] e1,
                        input logic [22:0] e2, input logic [22:0] e3);
      chk({tag, "_h0"}, 64'(h0_out), 64'(e0));
      chk({tag, "_h1"}, 64'(h1_out), 64'(e1));
      chk({tag, "_h2"}, 64'(h2_out), 64'(e2));
      chk({tag, "_h3"}, 64'(h3_out), 64'(e3));
   endtask

   task automatic wr(input int addr, input int en, input int id, input int lvl, input int x, input int y);
      cfg_we    = 1'b1;
      cfg_addr  = addr[4:0];
      cfg_wdata = {en[0], id[8:0], lvl[4:0], x[9:0], y[9:0]};
      tick();
      cfg_we    = 1'b0;
   endtask

   task automatic pulse_line(input int y);
      line_start = 1'b1;
      line_y     = y[9:0];
      tick();
      line_start = 1'b0;
   endtask

   task automatic run_line(input int y);
      pulse_line(y);
      repeat (33) tick();
   endtask

   task automatic px(input int x);
      new_pixel = 1'b1;
      pixel_x   = x[9:0];
      tick();
      new_pixel = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (2) tick();
      chk_h("reset", 0, 0, 0, 0);
      chk("reset_hvalid", 64'(h_valid), 0);
      chk("reset_busy", 64'(scan_busy), 0);
      chk("reset_ovf", 64'(line_overflow), 0);
      rst_n = 1'b1;
      tick();

      // Single sprite, with a pixel in the commit cycle still seeing old slots
      wr(3, 1, 5, 2, 100, 50);
      pulse_line(52);
      chk("single_busy_start", 64'(scan_busy), 1);
      repeat (31) tick();
      px(100);
      chk_h("single_precommit", 0, 0, 0, 0);
      chk("single_busy_commit", 64'(scan_busy), 1);
      tick();
      chk("single_busy_done", 64'(scan_busy), 0);
      px(100);
      chk("single_hvalid", 64'(h_valid), 1);
      chk_h("single_x100", hd(2, 5, 0, 2, 1), 0, 0, 0);
      tick();
      chk("single_hvalid_drop", 64'(h_valid), 0);
      chk("single_hold", 64'(h0_out), 64'(hd(2, 5, 0, 2, 1)));
      px(107);
      chk("single_x107", 64'(h0_out), 64'(hd(2, 5, 7, 2, 0)));
      px(116);
      chk("single_x116", 64'(h0_out), 0);

      // Overflow: six matches, only entries 10..13 kept
      wr(3, 0, 0, 0, 0, 0);
      for (int e = 10; e < 16; e++) wr(e, 1, e + 11, e - 10, 200 + (e - 10) * 20, 0);
      run_line(0);
      chk("ovf_flag", 64'(line_overflow), 1);
      px(200);
      chk_h("ovf_x200", hd(0, 21, 0, 0, 1), 0, 0, 0);
      px(260);
      chk_h("ovf_x260", 0, 0, 0, hd(3, 24, 0, 0, 1));
      px(280);
      chk_h("ovf_x280", 0, 0, 0, 0);
      for (int e = 10; e < 16; e++) wr(e, 0, 0, 0, 0, 0);
      run_line(500);
      chk("ovf_clear", 64'(line_overflow), 0);
      px(200);
      chk_h("ovf_empty", 0, 0, 0, 0);

      // Wrap-around, with disabled and id-0 entries ahead of it
      wr(0, 0, 3, 1, 1018, 1020);
      wr(1, 1, 0, 1, 1018, 1020);
      wr(7, 1, 9, 1, 1018, 1020);
      run_line(3);
      px(2);
      chk_h("wrap_x2", hd(1, 9, 8, 7, 0), 0, 0, 0);

      // Restart: second line_start 5 cycles after the first
      wr(0, 0, 0, 0, 0, 0);
      wr(1, 0, 0, 0, 0, 0);
      wr(7, 0, 0, 0, 0, 0);
      wr(20, 1, 40, 4, 500, 10);
      wr(21, 1, 41, 5, 600, 35);
      busy_ok = 1'b1;
      pulse_line(10);
      for (int i = 0; i < 4; i++) begin
         busy_ok &= scan_busy;
         tick();
      end
      busy_ok &= scan_busy;
      pulse_line(40);
      for (int i = 0; i < 30; i++) begin
         busy_ok &= scan_busy;
         tick();
      end
      px(2);
      chk_h("restart_old_active", hd(1, 9, 8, 7, 0), 0, 0, 0);
      busy_ok &= scan_busy;
      tick();
      busy_ok &= scan_busy;
      chk("restart_busy", 64'(busy_ok), 1);
      tick();
      chk("restart_done", 64'(scan_busy), 0);
      px(500);
      chk_h("restart_x500", 0, 0, 0, 0);
      px(600);
      chk_h("restart_x600", hd(5, 41, 0, 5, 1), 0, 0, 0);

      // frame_start during scan
      pulse_line(40);
      repeat (3) tick();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("frame_busy", 64'(scan_busy), 0);
      repeat (40) tick();
      chk("frame_no_commit", 64'(scan_busy), 0);
      px(600);
      chk("frame_hvalid", 64'(h_valid), 1);
      chk_h("frame_x600", 0, 0, 0, 0);

      // Reset during scan clears table and slots
      run_line(40);
      px(600);
      chk("prereset_x600", 64'(h0_out), 64'(hd(5, 41, 0, 5, 1)));
      pulse_line(40);
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rst_busy", 64'(scan_busy), 0);
      chk("rst_h0", 64'(h0_out), 0);
      chk("rst_hvalid", 64'(h_valid), 0);
      repeat (40) tick();
      px(600);
      chk("rst_slots", 64'(h0_out), 0);
      run_line(40);
      px(600);
      chk_h("rst_table", 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sprite_line_scanner.md
SPRITE_LINE_SCANNER -- requirements
Module: sprite_line_scanner

Interface
REQ-001 Parameter: NUM_ENTRIES, 32, number of sprite table entries; the scan length in cycles equals this value.
REQ-002 clk  in  1  clock; all logic is on the rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 cfg_we  in  1  sprite table write strobe.
REQ-005 cfg_addr  in  5  sprite table entry index.
REQ-006 cfg_wdata  in  35  entry fields: [34] enable, [33:25] id, [24:20] level, [19:10] x, [9:0] y.
REQ-007 frame_start  in  1  one-cycle pulse at the start of each frame.
REQ-008 line_start  in  1  one-cycle pulse at the start of horizontal blanking.
REQ-009 line_y  in  10  number of the next line to display; sampled on line_start.
REQ-010 new_pixel  in  1  pixel strobe for an active pixel.
REQ-011 pixel_x  in  10  column of the current pixel; valid with new_pixel.
REQ-012 h0_out..h3_out  out  23 each  hit descriptor: [22:18] level, [17:9] id, [8:5] offset_x, [4:1] offset_y, [0] is_border.
REQ-013 h_valid  out  1  strobe marking the cycle in which h0_out..h3_out are valid.
REQ-014 scan_busy  out  1  high while the per-line scan runs.
REQ-015 line_overflow  out  1  high when more than 4 sprites matched the line latched at the last scan.

Function
REQ-016 Table: NUM_ENTRIES registers written on cfg_we; the write takes effect next cycle. A scan read of the same entry in the same cycle returns the old value.
REQ-017 State machine: IDLE, SCAN, COMMIT.
- IDLE -> SCAN on line_start: latch line_y, clear 4 pending slots, index = 0.
- SCAN: evaluate entry[index] each cycle, index + 1. After index NUM_ENTRIES-1, go to COMMIT.
- COMMIT: copy pending slots to active slots, go to IDLE. Total 33 cycles from line_start to active-slot update.
REQ-018 Match rule: enable = 1, id != 0, and (line_y_latched - y) mod 1024 < 16. dy = low 4 bits of the difference.
REQ-019 Matches fill pending slots 0..3 in ascending table order. Each slot stores level, id, x, dy and valid.
REQ-020 Overflow: a fifth or later match is discarded and sets a pending overflow flag. line_overflow takes the pending flag value at COMMIT.
REQ-021 line_start while in SCAN or COMMIT aborts the current scan and restarts from index 0 with the new line_y. Active slots are left unchanged.
REQ-022 scan_busy = 1 in SCAN and COMMIT, 0 in IDLE.
REQ-023 Pixel path, for each slot k, on new_pixel:
- dx = (pixel_x - x) mod 1024.
- Hit when the active slot is valid and dx < 16.
- hk_out <= {level, id, dx[3:0], dy, border}, where border = (dx[3:0] in {0,15}) or (dy in {0,15}).
- On no hit, hk_out <= 0.
REQ-024 h_valid <= new_pixel, giving 1-cycle latency. When new_pixel = 0, hk_out hold their last value.
REQ-025 The pixel path runs concurrently with the scan. It always uses the active slots, which change only at COMMIT.
REQ-026 frame_start: clear active slots, pending slots and line_overflow, and force IDLE. Priority: rst_n > frame_start > line_start > FSM progress.
REQ-027 Configuration writes are accepted in every state.

Reset
REQ-028 While rst_n = 0 at a clock edge: all table entries are zeroed, active and pending slots are invalidated, the state is IDLE, and index = 0.
REQ-029 While rst_n = 0 at a clock edge: h0_out..h3_out = 0, h_valid = 0, scan_busy = 0, line_overflow = 0.
REQ-030 Reset asserted mid-scan discards the scan. No COMMIT occurs.

Verification
REQ-031 Single sprite:
- Stimulus: entry 3 = {en 1, id 5, level 2, x 100, y 50}; line_start with line_y = 52; wait 33 cycles; new_pixel with pixel_x = 100.
- Response: h0_out = {2, 5, 0, 2, 1} with h_valid one cycle later; pixel_x = 107 gives h0_out = {2, 5, 7, 2, 0}; pixel_x = 116 gives h0_out = 0.
REQ-032 Overflow:
- Stimulus: 6 enabled sprites with y = 0; line_start with line_y = 0.
- Response: slots hold the entries with the 4 lowest indices; line_overflow = 1 after COMMIT; line_overflow = 0 after the next line with no matches.
REQ-033 Wrap-around:
- Stimulus: sprite y = 1020, x = 1018; line_y = 3; pixel_x = 2.
- Response: hit with dy = 7, dx = 8, is_border = 0.
REQ-034 Restart:
- Stimulus: line_start at line_y = 10, then a second line_start 5 cycles later at line_y = 40.
- Response: only sprites matching line 40 are committed, 33 cycles after the second pulse; scan_busy stays high throughout.
REQ-035 Disabled/zero entries:
- Stimulus: entry with en = 0, or entry with id = 0, placed at a matching position.
- Response: no slot is filled; hk_out = 0.
REQ-036 frame_start mid-scan:
- Stimulus: frame_start pulse during SCAN.
- Response: the next cycle has scan_busy = 0; subsequent pixels give all hk_out = 0 with h_valid following new_pixel.
